// File: rtl/bitty_pkg.sv
// Shared definitions for the BittyPro control unit: state codes, instruction
// field positions and operand-format encodings.
package bitty_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StLoadS = 3'd1;
  localparam state_t StLoadC = 3'd2;
  localparam state_t StExec  = 3'd3;
  localparam state_t StWb    = 3'd4;

  localparam logic FMT_REG = 1'b0;
  localparam logic FMT_IMM = 1'b1;

  localparam int unsigned SEL_LSB  = 2;
  localparam int unsigned MODE_BIT = 1;
  localparam int unsigned FMT_BIT  = 0;
  localparam int unsigned IMM_LSB  = 6;

  // Register index width; a 2-register file still needs one select bit.
  function automatic int unsigned reg_w(int unsigned num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/bitty_inst_decode.sv
// Combinational field extraction from a latched BittyPro instruction word.
module bitty_inst_decode
  import bitty_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned INST_W   = 16,
  parameter int unsigned DATA_W   = 16,
  localparam int unsigned REG_W   = reg_w(NUM_REGS)
) (
  input  logic [INST_W-1:0] inst_i,
  output logic [REG_W-1:0]  rx_o,
  output logic [REG_W-1:0]  ry_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [3:0]        sel_o,
  output logic              mode_o,
  output logic              fmt_o
);

  localparam int unsigned ImmW = INST_W - REG_W - IMM_LSB;

  logic [ImmW-1:0] imm_raw;

  always_comb begin
    rx_o    = inst_i[INST_W-1 -: REG_W];
    ry_o    = inst_i[INST_W-1-REG_W -: REG_W];
    imm_raw = inst_i[INST_W-1-REG_W : IMM_LSB];
    imm_o   = DATA_W'(imm_raw);
    sel_o   = inst_i[SEL_LSB +: 4];
    mode_o  = inst_i[MODE_BIT];
    fmt_o   = inst_i[FMT_BIT];
  end

endmodule

// File: rtl/bitty_control_fsm.sv
// Multi-cycle BittyPro controller: accepts one instruction per handshake and
// sequences S-load, C-load, optional ALU wait and writeback.
module bitty_control_fsm
  import bitty_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ALU_LAT  = 0,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned INST_W   = 16,
  localparam int unsigned REG_W   = reg_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_valid,
  input  logic [INST_W-1:0]   inst,
  output logic                ready,
  output logic [3:0]          sel,
  output logic                mode,
  output logic [REG_W-1:0]    mux_sel,
  output logic                imm_sel,
  output logic [DATA_W-1:0]   imm,
  output logic [NUM_REGS-1:0] reg_enable,
  output logic                s_enable,
  output logic                c_enable,
  output logic                done,
  output logic                err
);

  localparam logic [3:0] LatInit = (ALU_LAT > 0) ? 4'(ALU_LAT - 1) : 4'd0;
  localparam bit         HasExec = (ALU_LAT > 0);

  state_t              state_q, state_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [3:0]          cnt_q, cnt_d;

  logic [REG_W-1:0]    dec_rx, dec_ry;
  logic [DATA_W-1:0]   dec_imm;
  logic [3:0]          dec_sel;
  logic                dec_mode, dec_fmt;

  bitty_inst_decode #(
    .NUM_REGS (NUM_REGS),
    .INST_W   (INST_W),
    .DATA_W   (DATA_W)
  ) u_decode (
    .inst_i (inst_q),
    .rx_o   (dec_rx),
    .ry_o   (dec_ry),
    .imm_o  (dec_imm),
    .sel_o  (dec_sel),
    .mode_o (dec_mode),
    .fmt_o  (dec_fmt)
  );

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (inst_valid) begin
          inst_d  = inst;
          state_d = StLoadS;
        end
      end
      StLoadS: state_d = StLoadC;
      StLoadC: begin
        if (HasExec) begin
          state_d = StExec;
          cnt_d   = LatInit;
        end else begin
          state_d = StWb;
        end
      end
      StExec: begin
        if (cnt_q == 4'd0) begin
          state_d = StWb;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      inst_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode; everything defaults to idle-quiet.
  always_comb begin
    ready      = 1'b0;
    sel        = 4'd0;
    mode       = 1'b0;
    mux_sel    = '0;
    imm_sel    = 1'b0;
    imm        = '0;
    reg_enable = '0;
    s_enable   = 1'b0;
    c_enable   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      StIdle: ready = 1'b1;
      StLoadS: begin
        sel      = dec_sel;
        mode     = dec_mode;
        mux_sel  = dec_rx;
        s_enable = 1'b1;
      end
      StLoadC: begin
        sel      = dec_sel;
        mode     = dec_mode;
        c_enable = 1'b1;
        if (dec_fmt == FMT_IMM) begin
          imm_sel = 1'b1;
          imm     = dec_imm;
        end else begin
          mux_sel = dec_ry;
        end
      end
      StExec: begin
        sel  = dec_sel;
        mode = dec_mode;
      end
      StWb: begin
        sel  = dec_sel;
        mode = dec_mode;
        done = 1'b1;
        if (32'(dec_rx) < NUM_REGS) begin
          reg_enable = NUM_REGS'(1) << dec_rx;
        end else begin
          err = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bitty_control_fsm.sv
// Bench for bitty_control_fsm: two configurations (8 regs/no ALU wait and
// 6 regs/2-cycle ALU wait) driven with directed and random instructions.
module tb_bitty_control_fsm;

  typedef struct packed {
    logic        ready;
    logic [3:0]  sel;
    logic        mode;
    logic [3:0]  mux_sel;
    logic        imm_sel;
    logic [15:0] imm;
    logic [15:0] reg_en;
    logic        s_en;
    logic        c_en;
    logic        done;
    logic        err;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [15:0] i0 = '0, i1 = '0;

  logic        rdy0, rdy1, md0, md1, is0, is1, se0, se1, ce0, ce1, dn0, dn1, er0, er1;
  logic [3:0]  sl0, sl1;
  logic [2:0]  ms0, ms1;
  logic [15:0] im0, im1;
  logic [7:0]  re0;
  logic [5:0]  re1;

  int checks = 0;
  int errors = 0;

  obs_t obs [2];

  always #5 clk = ~clk;

  bitty_control_fsm #(.NUM_REGS(8), .ALU_LAT(0), .DATA_W(16), .INST_W(16)) dut0 (
    .clk(clk), .reset(reset), .inst_valid(v0), .inst(i0), .ready(rdy0), .sel(sl0),
    .mode(md0), .mux_sel(ms0), .imm_sel(is0), .imm(im0), .reg_enable(re0),
    .s_enable(se0), .c_enable(ce0), .done(dn0), .err(er0)
  );

  bitty_control_fsm #(.NUM_REGS(6), .ALU_LAT(2), .DATA_W(16), .INST_W(16)) dut1 (
    .clk(clk), .reset(reset), .inst_valid(v1), .inst(i1), .ready(rdy1), .sel(sl1),
    .mode(md1), .mux_sel(ms1), .imm_sel(is1), .imm(im1), .reg_enable(re1),
    .s_enable(se1), .c_enable(ce1), .done(dn1), .err(er1)
  );

  assign obs[0] = {rdy0, sl0, md0, 4'(ms0), is0, im0, 16'(re0), se0, ce0, dn0, er0};
  assign obs[1] = {rdy1, sl1, md1, 4'(ms1), is1, im1, 16'(re1), se1, ce1, dn1, er1};

  // Expected outputs k cycles after the accept edge (k=0 means idle).
  function automatic obs_t model(int nregs, int lat, logic [15:0] iw, int k);
    obs_t m;
    int w, rw, rx, ry, immv;
    m    = '0;
    w    = int'(iw);
    rw   = $clog2(nregs);
    rx   = w >> (16 - rw);
    ry   = (w >> (16 - 2 * rw)) & ((1 << rw) - 1);
    immv = (w >> 6) & ((1 << (10 - rw)) - 1);
    if (k == 0 || k > 3 + lat) begin
      m.ready = 1'b1;
    end else begin
      m.sel  = iw[5:2];
      m.mode = iw[1];
      if (k == 1) begin
        m.s_en    = 1'b1;
        m.mux_sel = 4'(rx);
      end else if (k == 2) begin
        m.c_en = 1'b1;
        if (iw[0]) begin
          m.imm_sel = 1'b1;
          m.imm     = 16'(immv);
        end else begin
          m.mux_sel = 4'(ry);
        end
      end else if (k == 3 + lat) begin
        m.done = 1'b1;
        if (rx < nregs) m.reg_en = 16'(1 << rx);
        else            m.err    = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic check(int d, obs_t e, string tag);
    checks++;
    assert (obs[d] === e) else begin
      errors++;
      $error("FAIL %s dut%0d: got %h expected %h", tag, d, obs[d], e);
    end
  endtask

  task automatic drive(int d, logic v, logic [15:0] w);
    if (d == 0) begin
      v0 = v;
      i0 = w;
    end else begin
      v1 = v;
      i1 = w;
    end
  endtask

  // busy: 0 = hold quiet, 1 = random valid/inst, 2 = valid with inst=FFFF.
  // abort_at > 0 asserts reset after checking that cycle.
  task automatic run(int d, logic [15:0] iw, int busy, int abort_at);
    int lat, nr;
    lat = (d == 0) ? 0 : 2;
    nr  = (d == 0) ? 8 : 6;
    @(negedge clk);
    drive(d, 1'b1, iw);
    check(d, model(nr, lat, iw, 0), "pre_accept");
    for (int k = 1; k <= 3 + lat; k++) begin
      @(negedge clk);
      case (busy)
        1:       drive(d, 1'($urandom_range(0, 1)), 16'($urandom));
        2:       drive(d, 1'b1, 16'hFFFF);
        default: drive(d, 1'b0, iw);
      endcase
      check(d, model(nr, lat, iw, k), $sformatf("step%0d_%h", k, iw));
      if (k == abort_at) begin
        drive(d, 1'b0, iw);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check(d, model(nr, lat, iw, 0), "abort_idle");
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check(d, model(nr, lat, iw, 0), "abort_quiet");
        end
        return;
      end
    end
    @(negedge clk);
    drive(d, 1'b0, iw);
    check(d, model(nr, lat, iw, 0), "post_wb");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check(0, model(8, 0, 16'h0, 0), "reset0");
    check(1, model(6, 2, 16'h0, 0), "reset1");
    reset = 1'b0;

    run(0, 16'h540C, 0, 0);
    run(0, 16'h2943, 0, 0);
    run(0, 16'h540C, 2, 0);
    run(0, 16'h540C, 0, 2);
    run(1, 16'h540C, 2, 0);
    run(1, 16'hE000, 0, 0);
    run(1, 16'h2943, 0, 0);
    run(1, 16'hC0FF, 1, 3);

    for (int n = 0; n < 60; n++) begin
      int d;
      d = n % 2;
      run(d, 16'($urandom), (n % 3 == 0) ? 1 : 0, (n % 11 == 5) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
